// File: rtl/axi_pad_partial_packet_pkg.sv
// Shared types and sizing helpers for the fixed-length packet padder.
package axi_pad_partial_packet_pkg;

  typedef enum logic [1:0] {
    ST_PASS = 2'd0,
    ST_PAD  = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  localparam int SR_ADDR_W = 8;
  localparam int SR_DATA_W = 32;

  // The word counter must be able to hold MAX_PKT_SIZE itself, not just MAX_PKT_SIZE-1.
  function automatic int cnt_width(input int max_pkt_size);
    return $clog2(max_pkt_size + 1);
  endfunction

endpackage

// File: rtl/axi_pad_partial_packet_if.sv
// Input/output AXI-Stream pair for the packet padder; slave is the block side.
interface axi_pad_partial_packet_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] i_tdata;
  logic             i_tlast;
  logic             i_tvalid;
  logic             i_tready;
  logic [WIDTH-1:0] o_tdata;
  logic             o_tlast;
  logic             o_tvalid;
  logic             o_tready;

  modport slave (
    input  i_tdata, i_tlast, i_tvalid,
    output i_tready,
    output o_tdata, o_tlast, o_tvalid,
    input  o_tready
  );

  modport master (
    output i_tdata, i_tlast, i_tvalid,
    input  i_tready,
    input  o_tdata, o_tlast, o_tvalid,
    output o_tready
  );
endinterface

// File: rtl/axi_pad_partial_packet_setting_reg.sv
// Single settings-bus register: captures data_in when strobed at its address.
module setting_reg #(
  parameter int               MY_ADDR  = 0,
  parameter int               AWIDTH   = 8,
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] AT_RESET = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              strobe,
  input  logic [AWIDTH-1:0] addr,
  input  logic [WIDTH-1:0]  data_in,
  output logic [WIDTH-1:0]  out
);

  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_d;

  always_comb begin
    out_d = out_q;
    if (strobe && (addr == AWIDTH'(MY_ADDR))) begin
      out_d = data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= AT_RESET;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: rtl/axi_pad_partial_packet.sv
// Forces every output packet to exactly pkt_size words: pads short input packets,
// splits or truncates long ones.
//
// state   | meaning
// ST_PASS | forwarding input words, tracking position inside the output packet
// ST_PAD  | input packet ended early; filling the rest with PAD_VALUE
// ST_DROP | output packet already closed; discarding the rest of a long input packet
module axi_pad_partial_packet
  import axi_pad_partial_packet_pkg::*;
#(
  parameter int               WIDTH            = 32,
  parameter int               MAX_PKT_SIZE     = 1024,
  parameter int               SR_PKT_SIZE_ADDR = 1,
  parameter int               DEFAULT_PKT_SIZE = 1,
  parameter logic [WIDTH-1:0] PAD_VALUE        = '0,
  parameter bit               SPLIT_LONG       = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic                 set_stb,
  input  logic [SR_ADDR_W-1:0] set_addr,
  input  logic [SR_DATA_W-1:0] set_data,
  axi_pad_partial_packet_if.slave axis,
  output logic [15:0]          pad_pkt_cnt,
  output logic [15:0]          long_pkt_cnt
);

  localparam int CNT_W = cnt_width(MAX_PKT_SIZE);
  localparam logic [CNT_W-1:0] RST_SIZE = CNT_W'((DEFAULT_PKT_SIZE < 1) ? 1 : DEFAULT_PKT_SIZE);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] sr_pkt_size;
  logic             unused_set_data_hi;

  assign unused_set_data_hi = ^set_data[SR_DATA_W-1:CNT_W];

  setting_reg #(
    .MY_ADDR (SR_PKT_SIZE_ADDR),
    .AWIDTH  (SR_ADDR_W),
    .WIDTH   (CNT_W),
    .AT_RESET(RST_SIZE)
  ) u_setting_reg (
    .clk    (clk),
    .rst    (~reset_n),
    .strobe (set_stb),
    .addr   (set_addr),
    .data_in(set_data[CNT_W-1:0]),
    .out    (sr_pkt_size)
  );

  state_e           state_q,     state_d;
  logic [CNT_W-1:0] out_cnt_q,   out_cnt_d;
  logic [CNT_W-1:0] pkt_size_q,  pkt_size_d;
  logic             long_seen_q, long_seen_d;
  logic [15:0]      pad_cnt_q,   pad_cnt_d;
  logic [15:0]      long_cnt_q,  long_cnt_d;
  logic [WIDTH-1:0] o_tdata_q,   o_tdata_d;
  logic             o_tlast_q,   o_tlast_d;
  logic             o_tvalid_q,  o_tvalid_d;

  logic             ld;
  logic             idle;
  logic [CNT_W-1:0] sr_size_nz;
  logic [CNT_W-1:0] pkt_size;
  logic             boundary;
  logic             size_one;
  logic [CNT_W-1:0] out_cnt_next;
  logic             i_tready_c;

  assign ld         = ~o_tvalid_q | axis.o_tready;
  assign idle       = (state_q == ST_PASS) && (out_cnt_q == ONE);
  assign sr_size_nz = (sr_pkt_size == '0) ? ONE : sr_pkt_size;

  // While idle the live setting is used directly, so a packet starting right after a write sees it.
  assign pkt_size     = idle ? sr_size_nz : pkt_size_q;
  assign pkt_size_d   = pkt_size;
  assign boundary     = (out_cnt_q == pkt_size);
  assign size_one     = (pkt_size == ONE);
  assign out_cnt_next = boundary ? ONE : (out_cnt_q + ONE);

  always_comb begin
    state_d     = state_q;
    out_cnt_d   = out_cnt_q;
    long_seen_d = long_seen_q;
    pad_cnt_d   = pad_cnt_q;
    long_cnt_d  = long_cnt_q;
    o_tdata_d   = o_tdata_q;
    o_tlast_d   = o_tlast_q;
    o_tvalid_d  = ld ? 1'b0 : o_tvalid_q;
    i_tready_c  = 1'b0;

    case (state_q)
      ST_PASS: begin
        i_tready_c = ld;
        if (ld && axis.i_tvalid) begin
          o_tdata_d  = axis.i_tdata;
          o_tlast_d  = boundary;
          o_tvalid_d = 1'b1;
          out_cnt_d  = out_cnt_next;
          if (axis.i_tlast) begin
            long_seen_d = 1'b0;
            if (!boundary) begin
              state_d   = ST_PAD;
              pad_cnt_d = pad_cnt_q + 16'd1;
            end
          end else if (boundary && !size_one) begin
            // Count a long input packet once, even if it spans several chunks.
            if (!long_seen_q) begin
              long_cnt_d  = long_cnt_q + 16'd1;
              long_seen_d = 1'b1;
            end
            if (!SPLIT_LONG) begin
              state_d = ST_DROP;
            end
          end
        end
      end
      ST_PAD: begin
        if (ld) begin
          o_tdata_d  = PAD_VALUE;
          o_tlast_d  = boundary;
          o_tvalid_d = 1'b1;
          out_cnt_d  = out_cnt_next;
          if (boundary) begin
            state_d = ST_PASS;
          end
        end
      end
      ST_DROP: begin
        i_tready_c = 1'b1;
        if (axis.i_tvalid && axis.i_tlast) begin
          state_d     = ST_PASS;
          long_seen_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_PASS;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      state_q     <= ST_PASS;
      out_cnt_q   <= ONE;
      long_seen_q <= 1'b0;
      pad_cnt_q   <= '0;
      long_cnt_q  <= '0;
      o_tdata_q   <= '0;
      o_tlast_q   <= 1'b0;
      o_tvalid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_cnt_q   <= out_cnt_d;
      long_seen_q <= long_seen_d;
      pad_cnt_q   <= pad_cnt_d;
      long_cnt_q  <= long_cnt_d;
      o_tdata_q   <= o_tdata_d;
      o_tlast_q   <= o_tlast_d;
      o_tvalid_q  <= o_tvalid_d;
    end
  end

  // Soft clear leaves the latched size alone; it is re-latched anyway once idle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pkt_size_q <= RST_SIZE;
    end else begin
      pkt_size_q <= pkt_size_d;
    end
  end

  assign axis.i_tready = i_tready_c;
  assign axis.o_tdata  = o_tdata_q;
  assign axis.o_tlast  = o_tlast_q;
  assign axis.o_tvalid = o_tvalid_q;
  assign pad_pkt_cnt   = pad_cnt_q;
  assign long_pkt_cnt  = long_cnt_q;

endmodule

// File: tb/tb_axi_pad_partial_packet.sv
// Bench for axi_pad_partial_packet: one split-mode and one truncate-mode instance
// sharing clock, reset and settings bus, checked against a packet-level model.
module tb_axi_pad_partial_packet;

  localparam logic [31:0] PADV    = 32'hA5A5_5A5A;
  localparam int          SR_ADDR = 1;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear = 1'b0;
  logic        set_stb = 1'b0;
  logic [7:0]  set_addr = 8'd0;
  logic [31:0] set_data = 32'd0;
  logic [15:0] pad0, long0, pad1, long1;

  logic [31:0] drv_data = 32'd0;
  logic        drv_last = 1'b0;
  logic        drv_valid = 1'b0;
  logic        o_rdy = 1'b1;
  bit          rnd_rdy = 1'b0;
  int          sel = 0;

  int total = 0;
  int bad = 0;
  int hold_viol = 0;
  int exp_pad[2];
  int exp_long[2];

  beat_t got0[$], got1[$], exp_q[$], act_q[$];
  logic [1:0] prev_stall = 2'b00;
  beat_t      prev_beat[2];

  always #5 clk = ~clk;

  axi_pad_partial_packet_if #(.WIDTH(32)) if0 ();
  axi_pad_partial_packet_if #(.WIDTH(32)) if1 ();

  assign if0.i_tdata  = drv_data;
  assign if0.i_tlast  = drv_last;
  assign if0.i_tvalid = drv_valid && (sel == 0);
  assign if0.o_tready = o_rdy;
  assign if1.i_tdata  = drv_data;
  assign if1.i_tlast  = drv_last;
  assign if1.i_tvalid = drv_valid && (sel == 1);
  assign if1.o_tready = o_rdy;

  axi_pad_partial_packet #(
    .WIDTH(32), .MAX_PKT_SIZE(1024), .SR_PKT_SIZE_ADDR(SR_ADDR),
    .DEFAULT_PKT_SIZE(1), .PAD_VALUE(PADV), .SPLIT_LONG(1'b1)
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .clear(clear), .set_stb(set_stb),
    .set_addr(set_addr), .set_data(set_data), .axis(if0),
    .pad_pkt_cnt(pad0), .long_pkt_cnt(long0)
  );

  axi_pad_partial_packet #(
    .WIDTH(32), .MAX_PKT_SIZE(1024), .SR_PKT_SIZE_ADDR(SR_ADDR),
    .DEFAULT_PKT_SIZE(1), .PAD_VALUE(PADV), .SPLIT_LONG(1'b0)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .clear(clear), .set_stb(set_stb),
    .set_addr(set_addr), .set_data(set_data), .axis(if1),
    .pad_pkt_cnt(pad1), .long_pkt_cnt(long1)
  );

  always @(posedge clk) begin
    #1;
    o_rdy = rnd_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  // Output monitor: records handshaken beats and flags any change while stalled.
  always @(negedge clk) begin
    if (!reset_n || clear) begin
      prev_stall = 2'b00;
    end else begin
      if (prev_stall[0] && !(if0.o_tvalid && if0.o_tdata == prev_beat[0].d && if0.o_tlast == prev_beat[0].l))
        hold_viol++;
      if (prev_stall[1] && !(if1.o_tvalid && if1.o_tdata == prev_beat[1].d && if1.o_tlast == prev_beat[1].l))
        hold_viol++;
      if (if0.o_tvalid && if0.o_tready) got0.push_back(beat_t'({if0.o_tdata, if0.o_tlast}));
      if (if1.o_tvalid && if1.o_tready) got1.push_back(beat_t'({if1.o_tdata, if1.o_tlast}));
      prev_stall[0] = if0.o_tvalid && !if0.o_tready;
      prev_stall[1] = if1.o_tvalid && !if1.o_tready;
      prev_beat[0]  = beat_t'({if0.o_tdata, if0.o_tlast});
      prev_beat[1]  = beat_t'({if1.o_tdata, if1.o_tlast});
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_size(input int v);
    set_stb  = 1'b1;
    set_addr = 8'(SR_ADDR);
    set_data = 32'(v);
    cycles(1);
    set_stb = 1'b0;
    cycles(2);
  endtask

  // Sends one packet to the selected instance; optionally writes wr_val while word wr_at is offered.
  task automatic send_pkt(input int n, input logic [31:0] base, input int wr_at, input int wr_val);
    int  k = 0;
    int  guard = 0;
    bit  acc;
    while (k < n && guard < 2000) begin
      drv_valid = 1'b1;
      drv_data  = base + 32'(k);
      drv_last  = (k == n - 1);
      set_stb   = (k == wr_at);
      set_addr  = 8'(SR_ADDR);
      set_data  = 32'(wr_val);
      @(negedge clk);
      acc = (sel == 0) ? if0.i_tready : if1.i_tready;
      @(posedge clk);
      #1;
      if (acc) k++;
      guard++;
    end
    drv_valid = 1'b0;
    drv_last  = 1'b0;
    set_stb   = 1'b0;
    if (guard >= 2000) begin
      total++; bad++;
      $display("FAIL send_timeout sent=%0d required=%0d", k, n);
    end
  endtask

  task automatic collect();
    int guard = 0;
    while (((sel == 0) ? got0.size() : got1.size()) < exp_q.size() && guard < 2000) begin
      cycles(1);
      guard++;
    end
    cycles(6);
    act_q = (sel == 0) ? got0 : got1;
    got0.delete();
    got1.delete();
  endtask

  // Packet-level reference: what a fixed-length framer must emit for an n-word input packet.
  task automatic model(input int n, input int size, input logic [31:0] base);
    bit split = (sel == 0);
    int total_out;
    if (size <= 1) begin
      for (int k = 0; k < n; k++) exp_q.push_back(beat_t'({base + 32'(k), 1'b1}));
    end else begin
      if (n > size) exp_long[sel]++;
      if ((n % size != 0) && (n < size || split)) exp_pad[sel]++;
      total_out = (n <= size || split) ? ((n + size - 1) / size) * size : size;
      for (int k = 0; k < total_out; k++)
        exp_q.push_back(beat_t'({(k < n) ? base + 32'(k) : PADV, (k % size) == size - 1}));
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (if0.o_tvalid !== 1'b0) begin bad++; $display("FAIL rst_tvalid got=%b exp=0", if0.o_tvalid); end
    total++; if (if0.o_tlast !== 1'b0) begin bad++; $display("FAIL rst_tlast got=%b exp=0", if0.o_tlast); end
    total++; if (if0.o_tdata !== 32'd0) begin bad++; $display("FAIL rst_tdata got=%h exp=0", if0.o_tdata); end
    total++; if (pad0 !== 16'd0 || long0 !== 16'd0) begin bad++; $display("FAIL rst_cnt got=%0d/%0d exp=0/0", pad0, long0); end
    total++; if (if1.i_tready !== 1'b1) begin bad++; $display("FAIL rst_tready got=%b exp=1", if1.i_tready); end
    @(posedge clk); #1;
  endtask

  task automatic test_exact();
    sel = 0;
    write_size(4);
    model(4, 4, 32'hA000_0000);
    send_pkt(4, 32'hA000_0000, -1, 0);
    collect();
    total++; if (act_q.size() != exp_q.size()) begin bad++; $display("FAIL exact_len got=%0d exp=%0d", act_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < act_q.size(); k++) begin
      total++; if (act_q[k] !== exp_q[k]) begin bad++; $display("FAIL exact_beat%0d got=%h/%b exp=%h/%b", k, act_q[k].d, act_q[k].l, exp_q[k].d, exp_q[k].l); end
    end
    total++; if (pad0 !== 16'(exp_pad[0]) || long0 !== 16'(exp_long[0])) begin bad++; $display("FAIL exact_cnt got=%0d/%0d exp=%0d/%0d", pad0, long0, exp_pad[0], exp_long[0]); end
    exp_q.delete();
  endtask

  task automatic test_pad();
    int low = 0;
    sel = 0;
    model(2, 4, 32'hB000_0000);
    send_pkt(2, 32'hB000_0000, -1, 0);
    for (int g = 0; g < 20; g++) begin
      @(negedge clk);
      if (if0.i_tready) break;
      low++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    total++; if (low != 2) begin bad++; $display("FAIL pad_tready_low got=%0d exp=2", low); end
    collect();
    total++; if (act_q.size() != exp_q.size()) begin bad++; $display("FAIL pad_len got=%0d exp=%0d", act_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < act_q.size(); k++) begin
      total++; if (act_q[k] !== exp_q[k]) begin bad++; $display("FAIL pad_beat%0d got=%h/%b exp=%h/%b", k, act_q[k].d, act_q[k].l, exp_q[k].d, exp_q[k].l); end
    end
    total++; if (pad0 !== 16'(exp_pad[0]) || long0 !== 16'(exp_long[0])) begin bad++; $display("FAIL pad_cnt got=%0d/%0d exp=%0d/%0d", pad0, long0, exp_pad[0], exp_long[0]); end
    exp_q.delete();
  endtask

  task automatic test_split();
    sel = 0;
    model(6, 4, 32'hC000_0000);
    send_pkt(6, 32'hC000_0000, -1, 0);
    collect();
    total++; if (act_q.size() != exp_q.size()) begin bad++; $display("FAIL split_len got=%0d exp=%0d", act_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < act_q.size(); k++) begin
      total++; if (act_q[k] !== exp_q[k]) begin bad++; $display("FAIL split_beat%0d got=%h/%b exp=%h/%b", k, act_q[k].d, act_q[k].l, exp_q[k].d, exp_q[k].l); end
    end
    total++; if (pad0 !== 16'(exp_pad[0]) || long0 !== 16'(exp_long[0])) begin bad++; $display("FAIL split_cnt got=%0d/%0d exp=%0d/%0d", pad0, long0, exp_pad[0], exp_long[0]); end
    exp_q.delete();
  endtask

  task automatic test_truncate();
    sel = 1;
    model(6, 4, 32'hD000_0000);
    send_pkt(6, 32'hD000_0000, -1, 0);
    model(4, 4, 32'hD100_0000);
    send_pkt(4, 32'hD100_0000, -1, 0);
    collect();
    total++; if (act_q.size() != exp_q.size()) begin bad++; $display("FAIL trunc_len got=%0d exp=%0d", act_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < act_q.size(); k++) begin
      total++; if (act_q[k] !== exp_q[k]) begin bad++; $display("FAIL trunc_beat%0d got=%h/%b exp=%h/%b", k, act_q[k].d, act_q[k].l, exp_q[k].d, exp_q[k].l); end
    end
    total++; if (pad1 !== 16'(exp_pad[1]) || long1 !== 16'(exp_long[1])) begin bad++; $display("FAIL trunc_cnt got=%0d/%0d exp=%0d/%0d", pad1, long1, exp_pad[1], exp_long[1]); end
    exp_q.delete();
  endtask

  task automatic test_size_change();
    sel = 0;
    model(4, 4, 32'hE000_0000);
    send_pkt(4, 32'hE000_0000, 2, 8);
    model(5, 8, 32'hE100_0000);
    send_pkt(5, 32'hE100_0000, -1, 0);
    write_size(0);
    model(3, 1, 32'hE200_0000);
    send_pkt(3, 32'hE200_0000, -1, 0);
    collect();
    total++; if (act_q.size() != exp_q.size()) begin bad++; $display("FAIL size_len got=%0d exp=%0d", act_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < act_q.size(); k++) begin
      total++; if (act_q[k] !== exp_q[k]) begin bad++; $display("FAIL size_beat%0d got=%h/%b exp=%h/%b", k, act_q[k].d, act_q[k].l, exp_q[k].d, exp_q[k].l); end
    end
    total++; if (pad0 !== 16'(exp_pad[0]) || long0 !== 16'(exp_long[0])) begin bad++; $display("FAIL size_cnt got=%0d/%0d exp=%0d/%0d", pad0, long0, exp_pad[0], exp_long[0]); end
    exp_q.delete();
  endtask

  task automatic test_random();
    int n, sz;
    logic [31:0] base;
    rnd_rdy = 1'b1;
    for (int s = 0; s < 2; s++) begin
      sel = s;
      for (int p = 0; p < 10; p++) begin
        sz   = $urandom_range(1, 6);
        n    = $urandom_range(1, 12);
        base = $urandom & 32'hFFFF_FF00;
        write_size(sz);
        model(n, sz, base);
        send_pkt(n, base, -1, 0);
      end
      collect();
      total++; if (act_q.size() != exp_q.size()) begin bad++; $display("FAIL rand%0d_len got=%0d exp=%0d", s, act_q.size(), exp_q.size()); end
      for (int k = 0; k < exp_q.size() && k < act_q.size(); k++) begin
        total++; if (act_q[k] !== exp_q[k]) begin bad++; $display("FAIL rand%0d_beat%0d got=%h/%b exp=%h/%b", s, k, act_q[k].d, act_q[k].l, exp_q[k].d, exp_q[k].l); end
      end
      total++; if ((s == 0 ? pad0 : pad1) !== 16'(exp_pad[s]) || (s == 0 ? long0 : long1) !== 16'(exp_long[s])) begin
        bad++; $display("FAIL rand%0d_cnt got=%0d/%0d exp=%0d/%0d", s, (s == 0 ? pad0 : pad1), (s == 0 ? long0 : long1), exp_pad[s], exp_long[s]);
      end
      exp_q.delete();
    end
    total++; if (hold_viol != 0) begin bad++; $display("FAIL rand_hold got=%0d exp=0", hold_viol); end
  endtask

  task automatic test_reset_mid_pad();
    sel = 0;
    rnd_rdy = 1'b1;
    write_size(8);
    send_pkt(1, 32'hF000_0000, -1, 0);
    cycles(3);
    reset_n = 1'b0;
    cycles(1);
    reset_n = 1'b1;
    got0.delete(); got1.delete(); exp_q.delete();
    exp_pad = '{0, 0};
    exp_long = '{0, 0};
    @(negedge clk);
    total++; if (if0.o_tvalid !== 1'b0) begin bad++; $display("FAIL midrst_tvalid got=%b exp=0", if0.o_tvalid); end
    total++; if (pad0 !== 16'd0 || long0 !== 16'd0) begin bad++; $display("FAIL midrst_cnt got=%0d/%0d exp=0/0", pad0, long0); end
    total++; if (if0.i_tready !== 1'b1 && o_rdy === 1'b1) begin bad++; $display("FAIL midrst_tready got=%b exp=1", if0.i_tready); end
    @(posedge clk); #1;
    write_size(4);
    model(3, 4, 32'hF100_0000);
    send_pkt(3, 32'hF100_0000, -1, 0);
    collect();
    total++; if (act_q.size() != exp_q.size()) begin bad++; $display("FAIL midrst_len got=%0d exp=%0d", act_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < act_q.size(); k++) begin
      total++; if (act_q[k] !== exp_q[k]) begin bad++; $display("FAIL midrst_beat%0d got=%h/%b exp=%h/%b", k, act_q[k].d, act_q[k].l, exp_q[k].d, exp_q[k].l); end
    end
    total++; if (pad0 !== 16'(exp_pad[0])) begin bad++; $display("FAIL midrst_pad got=%0d exp=%0d", pad0, exp_pad[0]); end
    total++; if (hold_viol != 0) begin bad++; $display("FAIL midrst_hold got=%0d exp=0", hold_viol); end
    exp_q.delete();
    rnd_rdy = 1'b0;
  endtask

  task automatic test_clear();
    sel = 0;
    cycles(2);
    clear = 1'b1;
    cycles(1);
    clear = 1'b0;
    exp_pad = '{0, 0};
    exp_long = '{0, 0};
    @(negedge clk);
    total++; if (pad0 !== 16'd0 || if0.o_tvalid !== 1'b0) begin bad++; $display("FAIL clear_state got=%0d/%b exp=0/0", pad0, if0.o_tvalid); end
    @(posedge clk); #1;
    got0.delete();
    model(2, 4, 32'h1200_0000);
    send_pkt(2, 32'h1200_0000, -1, 0);
    collect();
    total++; if (act_q.size() != exp_q.size()) begin bad++; $display("FAIL clear_len got=%0d exp=%0d", act_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < act_q.size(); k++) begin
      total++; if (act_q[k] !== exp_q[k]) begin bad++; $display("FAIL clear_beat%0d got=%h/%b exp=%h/%b", k, act_q[k].d, act_q[k].l, exp_q[k].d, exp_q[k].l); end
    end
    total++; if (pad0 !== 16'(exp_pad[0])) begin bad++; $display("FAIL clear_pad got=%0d exp=%0d", pad0, exp_pad[0]); end
    exp_q.delete();
  endtask

  initial begin
    exp_pad  = '{0, 0};
    exp_long = '{0, 0};
    reset_n  = 1'b0;
    cycles(3);
    reset_n = 1'b1;
    test_reset();
    test_exact();
    test_pad();
    test_split();
    test_truncate();
    test_size_change();
    test_random();
    test_reset_mid_pad();
    test_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
